vga_timing_gen: RTL and testbench

// - Parametrised VGA raster engine for the DE1-SoC top level; drives the ADV7123 DAC pins
//   (vga_r/g/b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk) from the single 50 MHz clock.
// - Generates pixel clock-enable, h/v counters and sync/blank timing for any mode set by parameters.
// - Exposes pixel coordinates and a request strobe so a downstream pixel source supplies RGB,

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_pixel_ce.sv | 39 +++
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA types: colour triplet, mode descriptor, standard mode constants
// and the 8-bar test-pattern colour table.
package vga_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [15:0] h_disp;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_disp;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480_60 = '{
        16'd640, 16'd16, 16'd96, 16'd48,
        16'd480, 16'd10, 16'd2,  16'd33,
        1'b0, 1'b0
    };

    localparam vga_mode_t VGA_800x600_72 = '{
        16'd800, 16'd56, 16'd120, 16'd64,
        16'd600, 16'd37, 16'd6,   16'd23,
        1'b1, 1'b1
    };

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [0:7][23:0] TP_COLORS = {
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic rgb_t tp_color(input logic [2:0] bar);
        return rgb_t'(TP_COLORS[bar]);
    endfunction

endpackage

// File: rtl/vga_pixel_ce.sv
// Pixel-rate divider: one-clk pix_ce strobe every PIX_DIV clocks plus a
// registered DAC sample clock that is high for the first half of each pixel.
module vga_pixel_ce #(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic pix_ce,
    output logic vga_clk
);

    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(PIX_DIV / 2);

    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;

    always_comb begin
        div_nxt = '0;
        if (en && (div != LAST)) div_nxt = div + 1'b1;
    end

    // vga_clk is computed from the next divider value so it is a clean flop
    // output aligned with the divider phase it describes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div     <= '0;
            vga_clk <= 1'b0;
        end else begin
            div     <= div_nxt;
            vga_clk <= en && (div_nxt < HALF);
        end
    end

    assign pix_ce = en && (div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: h/v counters, sync/blank timing and a
// one-pixel re-timed colour path to the DAC. Define VGA_TEST_PATTERN_EN for colour bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV = 2,
    parameter int H_DISP  = int'(VGA_640x480_60.h_disp),
    parameter int H_FP    = int'(VGA_640x480_60.h_fp),
    parameter int H_SYNC  = int'(VGA_640x480_60.h_sync),
    parameter int H_BP    = int'(VGA_640x480_60.h_bp),
    parameter int V_DISP  = int'(VGA_640x480_60.v_disp),
    parameter int V_FP    = int'(VGA_640x480_60.v_fp),
    parameter int V_SYNC  = int'(VGA_640x480_60.v_sync),
    parameter int V_BP    = int'(VGA_640x480_60.v_bp),
    parameter bit HS_POL  = VGA_640x480_60.hs_pol,
    parameter bit VS_POL  = VGA_640x480_60.vs_pol,
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic [23:0]   rgb_in,
    output logic          pix_req,
    output logic          pix_ce,
    output logic [HW-1:0] pix_x,
    output logic [VW-1:0] pix_y,
    output logic          frame_start,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_blank_n,
    output logic          vga_sync_n,
    output logic          vga_clk
);

    if (PIX_DIV < 2) begin : g_bad_pix_div
        $error("vga_timing_gen: PIX_DIV must be >= 2");
    end

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_last, v_last;
    logic          hs_act, vs_act;
    rgb_t          pix_rgb;
    rgb_t          out_rgb;

    vga_pixel_ce #(.PIX_DIV(PIX_DIV)) u_pixel_ce (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .pix_ce  (pix_ce),
        .vga_clk (vga_clk)
    );

    assign h_last = (hcnt == HW'(H_TOTAL - 1));
    assign v_last = (vcnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!en) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Compare in 32 bits so sync windows ending exactly at H_TOTAL never truncate.
    assign pix_req = (32'(hcnt) < H_DISP) && (32'(vcnt) < V_DISP);
    assign hs_act  = (32'(hcnt) >= H_DISP + H_FP) && (32'(hcnt) < H_DISP + H_FP + H_SYNC);
    assign vs_act  = (32'(vcnt) >= V_DISP + V_FP) && (32'(vcnt) < V_DISP + V_FP + V_SYNC);

    assign pix_x       = hcnt;
    assign pix_y       = vcnt;
    assign frame_start = pix_ce && (hcnt == '0) && (vcnt == '0);

`ifdef VGA_TEST_PATTERN_EN
    localparam bit H_POW2 = (H_DISP >= 8) && ((H_DISP & (H_DISP - 1)) == 0);
    logic [2:0] bar;
    logic       unused_rgb;

    assign unused_rgb = ^rgb_in;

    if (H_POW2) begin : g_bar_slice
        localparam int HDB = $clog2(H_DISP);
        assign bar = hcnt[HDB-1 -: 3];
    end else begin : g_bar_cmp
        localparam int XW = HW + 3;
        logic [XW-1:0] x8;
        assign x8 = {hcnt, 3'b000};
        // bar = number of bar boundaries k*H_DISP/8 already passed
        always_comb begin
            bar = 3'd0;
            for (int k = 1; k < 8; k++) begin
                if (x8 >= XW'(k * H_DISP)) bar = bar + 3'd1;
            end
        end
    end

    assign pix_rgb = tp_color(bar);
`else
    assign pix_rgb = rgb_t'(rgb_in);
`endif

    // Syncs and colour share this one register stage, so they stay aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_rgb     <= '0;
            vga_blank_n <= 1'b0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
        end else if (!en) begin
            out_rgb     <= '0;
            vga_blank_n <= 1'b0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
        end else if (pix_ce) begin
            out_rgb     <= pix_req ? pix_rgb : '0;
            vga_blank_n <= pix_req;
            vga_hs      <= hs_act ? HS_POL : ~HS_POL;
            vga_vs      <= vs_act ? VS_POL : ~VS_POL;
        end
    end

    assign vga_r      = out_rgb.r;
    assign vga_g      = out_rgb.g;
    assign vga_b      = out_rgb.b;
    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a reduced 64x12 raster: per-clock
// closed-form raster expectations plus hand-computed boundary, en-gap and reset checks.
module tb_vga_timing_gen;

    localparam int PD  = 2;
    localparam int HD  = 48, HFP = 4, HS = 8, HBP = 4, HT = 64;
    localparam int VD  = 6,  VFP = 2, VS = 2, VBP = 2, VT = 12;
    localparam int HW  = 6,  VW  = 4;
    localparam int FRAME_CLK = HT * VT * PD;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic [23:0]   rgb_in = '0;
    logic          pix_req, pix_ce, frame_start;
    logic [HW-1:0] pix_x;
    logic [VW-1:0] pix_y;
    logic [7:0]    vga_r, vga_g, vga_b;
    logic          vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .PIX_DIV(PD),
        .H_DISP(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_DISP(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .rgb_in(rgb_in),
        .pix_req(pix_req), .pix_ce(pix_ce), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .vga_clk(vga_clk)
    );

    wire [41:0] obs_vec = {pix_x, pix_y, pix_ce, frame_start, pix_req, vga_clk,
                           vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b};
    wire [23:0] pins_rgb = {vga_r, vga_g, vga_b};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ramp(input int x, input int y);
        return {8'(x), 8'(y * 16), 8'(x + y)};
    endfunction

    function automatic logic [23:0] bar_colour(input int x);
        case ((x * 8) / HD)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] pix_colour(input int x, input int y);
`ifdef VGA_TEST_PATTERN_EN
        return (y >= 0) ? bar_colour(x) : 24'h0;
`else
        return ramp(x, y);
`endif
    endfunction

    // Sample s counts negedges since release; pixel index n = s/PD, pins show pixel n-1.
    function automatic logic [41:0] expect_at(input int s);
        int n, x, y, m, mx, my;
        logic ce, hs, vs, bl;
        logic [23:0] c;
        n  = s / PD;
        x  = n % HT;
        y  = (n / HT) % VT;
        ce = ((s % PD) == PD - 1);
        if (n == 0) begin
            hs = 1'b1; vs = 1'b1; bl = 1'b0; c = '0;
        end else begin
            m  = n - 1;
            mx = m % HT;
            my = (m / HT) % VT;
            bl = (mx < HD) && (my < VD);
            c  = bl ? pix_colour(mx, my) : 24'h0;
            hs = !((mx >= HD + HFP) && (mx < HD + HFP + HS));
            vs = !((my >= VD + VFP) && (my < VD + VFP + VS));
        end
        return {6'(x), 4'(y), ce, ce && (x == 0) && (y == 0), (x < HD) && (y < VD),
                ((s % PD) < PD / 2), hs, vs, bl, 1'b0, c};
    endfunction

    task automatic run_raster(input int nsamp);
        int hs_fall = -1, vs_fall = -1, blank_cnt = 0;
        logic hs_prev = 1'b1, vs_prev = 1'b1;
        int n;
        for (int s = 1; s <= nsamp; s++) begin
            @(negedge clk);
            chk("raster", 64'(obs_vec), 64'(expect_at(s)));
            if (hs_prev && !vga_hs) begin
                if (hs_fall > 0) chk("hs_period", 64'(s - hs_fall), 64'(128));
                hs_fall = s;
            end
            if (!hs_prev && vga_hs && hs_fall > 0) chk("hs_low", 64'(s - hs_fall), 64'(16));
            if (vs_prev && !vga_vs) begin
                if (vs_fall > 0) chk("vs_period", 64'(s - vs_fall), 64'(1536));
                vs_fall = s;
            end
            if (!vs_prev && vga_vs && vs_fall > 0) chk("vs_low", 64'(s - vs_fall), 64'(256));
            hs_prev = vga_hs;
            vs_prev = vga_vs;
            if (s >= 2 && s <= 1537 && vga_blank_n) blank_cnt++;
            if (s == 1537) chk("blank_per_frame", 64'(blank_cnt), 64'(576));
            if (s == 127)  chk("x_last", 64'({pix_x, pix_y}), 64'({6'd63, 4'd0}));
            if (s == 128)  chk("x_wrap_y_inc", 64'({pix_x, pix_y}), 64'({6'd0, 4'd1}));
            if (s == 1535) chk("frame_last", 64'({pix_x, pix_y}), 64'({6'd63, 4'd11}));
            if (s == 1537) chk("frame_start_wrap", 64'({pix_x, pix_y, frame_start}), 64'({6'd0, 4'd0, 1'b1}));
            if (s == 96)   chk("x47_active", 64'(vga_blank_n), 64'(1));
            if (s == 98)   chk("x48_blanked", 64'({vga_blank_n, pins_rgb}), 64'({1'b0, 24'h0}));
`ifdef VGA_TEST_PATTERN_EN
            if (s == 2)    chk("bar0_x0", 64'(pins_rgb), 64'(24'hFFFFFF));
            if (s == 12)   chk("bar0_x5", 64'(pins_rgb), 64'(24'hFFFFFF));
            if (s == 14)   chk("bar1_x6", 64'(pins_rgb), 64'(24'hFFFF00));
            if (s == 86)   chk("bar7_x42", 64'(pins_rgb), 64'(24'h000000));
`else
            if (s == 22)   chk("ramp_x10", 64'(pins_rgb), 64'(24'h0A000A));
`endif
            n = s / PD;
            rgb_in = pix_colour(n % HT, (n / HT) % VT);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_counters", 64'({pix_x, pix_y}), 64'(0));
        chk("rst_strobes", 64'({pix_ce, frame_start, vga_clk}), 64'(0));
        chk("rst_pins", 64'({vga_hs, vga_vs, vga_blank_n, vga_sync_n, pins_rgb}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 24'h0}));

        // Release with en high; run past two frames up to pixel (30,4) of frame 3
        rgb_in  = ramp(0, 0);
        reset_n = 1'b1;
        en      = 1'b1;
        run_raster((2 * HT * VT + 4 * HT + 30) * PD + PD - 1);
        chk("drop_pos", 64'({pix_x, pix_y}), 64'({6'd30, 4'd4}));

        // en gap of 10 clk: everything idle
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("en_gap_idle",
                64'({pix_x, pix_y, pix_ce, frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n, pins_rgb}),
                64'({6'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0}));
        end

        // Re-enable restarts at (0,0); run into the hsync of line 1 (x=54)
        rgb_in = pix_colour(0, 0);
        en     = 1'b1;
        run_raster(FRAME_CLK + (HT + 54) * PD);
        chk("hs_active_pre_reset", 64'({pix_x, pix_y, vga_hs}), 64'({6'd54, 4'd1, 1'b0}));

        // Async reset mid-hsync
        reset_n = 1'b0;
        #1;
        chk("rst_async_hs", 64'(vga_hs), 64'(1));
        chk("rst_async_cnt", 64'({pix_x, pix_y, vga_blank_n, vga_clk}), 64'(0));
        repeat (3) @(negedge clk);
        rgb_in  = pix_colour(0, 0);
        reset_n = 1'b1;
        run_raster(FRAME_CLK + 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
